uart_response_framer: RTL and testbench
=======================================

Name: uart_response_framer

Overview:
- Sits directly downstream of the task output stream and the byte-count stage, feeding the UART TX byte interface.
- Buffers TASK_OUTPUT_WIDTH-wide result words in an internal FIFO until the end of the answer (last beat).
- Then emits a response frame byte by byte: a 4-byte length header taken from answer_size_in_bytes, followed by the buffered payload bytes.

Parameters:
- TASK_OUTPUT_WIDTH, 32, width of one result word in bits; must be a multiple of 8.
- FIFO_DEPTH, 256, result words buffered per answer; power of two, at least 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- input_valid  in  1  result word valid.
- input_last  in  1  final word of the answer; qualified by input_valid.
- input_data  in  TASK_OUTPUT_WIDTH  result word.
- input_ready  out  1  word accepted when input_valid && input_ready.
- answer_size_in_bytes  in  32  byte count from the counting stage.
- tx_data  out  8  byte to the UART TX.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART TX accepts the byte when tx_valid && tx_ready.
- frame_done  out  1  one-cycle pulse after the last frame byte is accepted.
- length_mismatch  out  1  sticky; set when the latched length differs from the buffered byte count.
- busy  out  1  high in every state except COLLECT.

Behaviour:
- Derived constant: BYTES_PER_WORD = TASK_OUTPUT_WIDTH/8.
- Reset (asynchronous, any state): state=COLLECT, FIFO empty, word count=0, byte index=0.
  - All outputs 0, except input_ready=1.
  - length_mismatch is cleared only by reset.
- COLLECT state:
  - input_ready = !fifo_full.
  - Every handshake pushes input_data and increments the word count.
  - A handshake with input_last=1 moves to LATCH on the next cycle.
  - A full FIFO backpressures the input; no word is ever dropped.
  - input_last without input_valid is ignored.
- LATCH state, one cycle long:
  - input_ready=0.
  - Capture answer_size_in_bytes into len_reg, which allows the counter one cycle to settle.
  - Compare len_reg against word count × BYTES_PER_WORD (32-bit); if they differ, set length_mismatch.
  - Go to HEADER.
- HEADER state:
  - Send len_reg as 4 bytes, LSB first (bits [7:0], [15:8], [23:16], [31:24]).
  - Advance the byte index only on a tx handshake.
  - After byte 3 is accepted: go to PAYLOAD if the word count is nonzero, else go to DONE.
- PAYLOAD state:
  - Send each FIFO head word LSB byte first, BYTES_PER_WORD bytes per word.
  - Pop the word when its final byte is accepted.
  - After the final byte of the final word, go to DONE.
  - Frame length is always driven by the buffered word count, never by len_reg.
- DONE state, one cycle long:
  - frame_done=1, tx_valid=0, word count cleared, return to COLLECT.
  - Back-to-back answers: input_ready is low from LATCH through DONE.
- tx handshake rules:
  - tx_valid is asserted in HEADER/PAYLOAD and stays high until accepted.
  - tx_data is stable while tx_valid && !tx_ready.
  - tx_valid/tx_data are registered outputs, with zero-bubble throughput when tx_ready is held high.
- Latency: the first header byte appears on tx_valid 2 cycles after the last input handshake (LATCH, then HEADER).
- Exactly FIFO_DEPTH words with last on the final word: accepted normally (full and last in the same cycle is legal).

Decomposition:
- Shared package (uart_pkg):
  - frame state enum: COLLECT, LATCH, HEADER, PAYLOAD, DONE.
  - LEN_HEADER_BYTES=4.
  - BYTES_PER_WORD helper function.
- One sub-module: sync_fifo, parameterised by width and depth.
  - Interface: push/pop/full/empty, first-word-fall-through, asynchronous reset.
  - Instantiated once for the result words.

Test Plan:
- 1 word 0xDDCCBBAA with last, answer_size_in_bytes=4, tx_ready=1 -> tx bytes 04 00 00 00 AA BB CC DD, frame_done pulses once, length_mismatch=0.
- 3 words with random tx_ready (50%) -> 16 bytes total in order, tx_data stable while stalled, no duplicated or lost byte.
- 256 words with tx_ready=0 until last -> input_ready low only after FIFO full; the 257th valid word is held, not lost; header reads 00 04 00 00.
- answer_size_in_bytes=8 while 3 words are buffered -> header 08 00 00 00, 12 payload bytes sent, length_mismatch=1 and it stays high.
- Assert i_rst mid-PAYLOAD (after 5 bytes) -> tx_valid=0 immediately, busy=0, input_ready=1; the next 1-word answer frames correctly.
- Two answers back-to-back (last on word 2, next valid asserted in the following cycle) -> second answer held until after frame_done, two correct frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART response framer.
// Holds the frame FSM states, the length-header size and the word/byte helper.
// Imported by the framer top; no logic of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        COLLECT,
        LATCH,
        HEADER,
        PAYLOAD,
        DONE
    } frame_state_e;

    localparam int unsigned LEN_HEADER_BYTES = 4;

    // Number of whole bytes carried by one result word.
    function automatic int unsigned bytes_per_word(input int unsigned width_bits);
        return width_bits / 8;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with asynchronous reset.
// Latency: a pushed word is visible on pop_data the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; callers gate on full/empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Status flags from the wrap bit, head word and next pointer values.
    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        pop_data = mem_q[rd_ptr_q[AW-1:0]];
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_response_framer.sv
// Buffers one answer of result words, then emits a 4-byte LSB-first length header and the payload bytes.
// Latency: first header byte on tx_valid 2 cycles after the last input handshake; zero-bubble while tx_ready is high.
// Backpressure: input_ready drops on a full FIFO and from LATCH through DONE; tx byte held stable until accepted.
module uart_response_framer
    import uart_pkg::*;
#(
    parameter int unsigned TASK_OUTPUT_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH        = 256
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         input_valid,
    input  logic                         input_last,
    input  logic [TASK_OUTPUT_WIDTH-1:0] input_data,
    output logic                         input_ready,
    input  logic [31:0]                  answer_size_in_bytes,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         frame_done,
    output logic                         length_mismatch,
    output logic                         busy
);

    localparam int unsigned BPW   = bytes_per_word(TASK_OUTPUT_WIDTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_W = ($clog2(BPW) > 2) ? $clog2(BPW) : 2;
    localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(LEN_HEADER_BYTES - 1);
    localparam logic [IDX_W-1:0] PAY_LAST = IDX_W'(BPW - 1);

    frame_state_e                 state_q, state_d;
    logic [CNT_W-1:0]             word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0]             byte_idx_q, byte_idx_d;
    logic [31:0]                  len_q, len_d;
    logic                         length_mismatch_q, length_mismatch_d;
    logic                         tx_valid_q, tx_valid_d;
    logic [7:0]                   tx_data_q, tx_data_d;
    logic [TASK_OUTPUT_WIDTH-1:0] word_q, word_d;
    logic [TASK_OUTPUT_WIDTH-1:0] word_shift;
    logic [7:0]                   hdr_next;
    logic                         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [TASK_OUTPUT_WIDTH-1:0] fifo_head;
    logic                         tx_hs;

    sync_fifo #(
        .WIDTH (TASK_OUTPUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (fifo_push),
        .push_data (input_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Frame FSM: next state, next tx byte and FIFO controls.
    // The output register always holds the byte on the wire, so the byte after it is
    // prepared on each handshake. A payload word is copied out of the FIFO (and popped)
    // when its first byte is loaded, and then shifted down a byte per handshake; this lets
    // the next FIFO head be ready in time for back-to-back words.
    always_comb begin
        state_d           = state_q;
        word_cnt_d        = word_cnt_q;
        byte_idx_d        = byte_idx_q;
        len_d             = len_q;
        length_mismatch_d = length_mismatch_q;
        tx_valid_d        = tx_valid_q;
        tx_data_d         = tx_data_q;
        word_d            = word_q;
        fifo_push         = 1'b0;
        fifo_pop          = 1'b0;
        input_ready       = 1'b0;
        tx_hs             = tx_valid_q && tx_ready;
        word_shift        = word_q >> 8;
        hdr_next          = len_q[15:8];
        if (byte_idx_q == IDX_W'(1)) begin
            hdr_next = len_q[23:16];
        end else if (byte_idx_q == IDX_W'(2)) begin
            hdr_next = len_q[31:24];
        end

        case (state_q)
            COLLECT: begin
                input_ready = !fifo_full;
                if (input_valid && !fifo_full) begin
                    fifo_push  = 1'b1;
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (input_last) begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                // The byte counter has had a cycle to settle after the last word.
                len_d = answer_size_in_bytes;
                if (answer_size_in_bytes != 32'(word_cnt_q) * BPW) begin
                    length_mismatch_d = 1'b1;
                end
                tx_valid_d = 1'b1;
                tx_data_d  = answer_size_in_bytes[7:0];
                byte_idx_d = '0;
                state_d    = HEADER;
            end
            HEADER: begin
                if (tx_hs) begin
                    if (byte_idx_q == HDR_LAST) begin
                        byte_idx_d = '0;
                        if (word_cnt_q != '0) begin
                            fifo_pop  = 1'b1;
                            word_d    = fifo_head;
                            tx_data_d = fifo_head[7:0];
                            state_d   = PAYLOAD;
                        end else begin
                            tx_valid_d = 1'b0;
                            state_d    = DONE;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                        tx_data_d  = hdr_next;
                    end
                end
            end
            PAYLOAD: begin
                if (tx_hs) begin
                    if (byte_idx_q == PAY_LAST) begin
                        byte_idx_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop  = 1'b1;
                            word_d    = fifo_head;
                            tx_data_d = fifo_head[7:0];
                        end else begin
                            tx_valid_d = 1'b0;
                            state_d    = DONE;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                        word_d     = word_shift;
                        tx_data_d  = word_shift[7:0];
                    end
                end
            end
            DONE: begin
                word_cnt_d = '0;
                state_d    = COLLECT;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q           <= COLLECT;
            word_cnt_q        <= '0;
            byte_idx_q        <= '0;
            len_q             <= '0;
            length_mismatch_q <= 1'b0;
            tx_valid_q        <= 1'b0;
            tx_data_q         <= '0;
            word_q            <= '0;
        end else begin
            state_q           <= state_d;
            word_cnt_q        <= word_cnt_d;
            byte_idx_q        <= byte_idx_d;
            len_q             <= len_d;
            length_mismatch_q <= length_mismatch_d;
            tx_valid_q        <= tx_valid_d;
            tx_data_q         <= tx_data_d;
            word_q            <= word_d;
        end
    end

    // Output decode.
    always_comb begin
        tx_valid        = tx_valid_q;
        tx_data         = tx_data_q;
        length_mismatch = length_mismatch_q;
        frame_done      = (state_q == DONE);
        busy            = (state_q != COLLECT);
    end

endmodule

// File: tb/tb_uart_response_framer.sv
module tb_uart_response_framer;

    logic        i_clk;
    logic        i_rst;
    logic        input_valid;
    logic        input_last;
    logic [31:0] input_data;
    logic        input_ready;
    logic [31:0] answer_size_in_bytes;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        frame_done;
    logic        length_mismatch;
    logic        busy;

    int          tests_run;
    int          tests_failed;
    int          fd_cnt;
    int          fd_before;
    int          waits;
    int          stalls;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];

    uart_response_framer dut (
        .i_clk                (i_clk),
        .i_rst                (i_rst),
        .input_valid          (input_valid),
        .input_last           (input_last),
        .input_data           (input_data),
        .input_ready          (input_ready),
        .answer_size_in_bytes (answer_size_in_bytes),
        .tx_data              (tx_data),
        .tx_valid             (tx_valid),
        .tx_ready             (tx_ready),
        .frame_done           (frame_done),
        .length_mismatch      (length_mismatch),
        .busy                 (busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Byte monitor: collects accepted bytes, counts frame_done pulses, checks stall stability.
    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(tx_valid), 32'd1);
                chk("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (frame_done) fd_cnt++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic send_word(input logic [31:0] d, input logic l, output int n);
        logic acc;
        input_valid = 1'b1;
        input_data  = d;
        input_last  = l;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 5000) begin
            @(negedge i_clk);
            acc = input_ready;
            @(posedge i_clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        input_valid = 1'b0;
        input_last  = 1'b0;
    endtask

    task automatic wait_frame(input int target, input logic rnd);
        int n;
        n = 0;
        while (fd_cnt < target && n < 5000) begin
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            @(posedge i_clk);
            #1;
            n++;
        end
        tx_ready = 1'b1;
        chk("frame_timeout", 32'(fd_cnt >= target), 32'd1);
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        fd_cnt       = 0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        i_rst        = 1'b1;
        input_valid  = 1'b0;
        input_last   = 1'b0;
        input_data   = '0;
        tx_ready     = 1'b0;
        answer_size_in_bytes = '0;

        // Reset state
        #22;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_input_ready", 32'(input_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_mismatch", 32'(length_mismatch), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Single word, full-speed TX, latency check
        tx_ready = 1'b1;
        answer_size_in_bytes = 32'd4;
        send_word(32'hDDCCBBAA, 1'b1, waits);
        chk("t1_latch_tx_valid", 32'(tx_valid), 32'd0);
        chk("t1_latch_input_ready", 32'(input_ready), 32'd0);
        chk("t1_latch_busy", 32'(busy), 32'd1);
        @(posedge i_clk);
        #1;
        chk("t1_first_valid", 32'(tx_valid), 32'd1);
        chk("t1_first_data", 32'(tx_data), 32'h04);
        wait_frame(1, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        chk("t1_done_pulses", 32'(fd_cnt), 32'd1);
        chk("t1_mismatch", 32'(length_mismatch), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        push_word(32'h00000004);
        push_word(32'hDDCCBBAA);
        check_frame("t1");

        // Three words with random TX backpressure
        answer_size_in_bytes = 32'd12;
        send_word(32'h03020100, 1'b0, waits);
        send_word(32'h07060504, 1'b0, waits);
        send_word(32'h0B0A0908, 1'b1, waits);
        wait_frame(2, 1'b1);
        push_word(32'h0000000C);
        push_word(32'h03020100);
        push_word(32'h07060504);
        push_word(32'h0B0A0908);
        check_frame("t2");
        chk("t2_mismatch", 32'(length_mismatch), 32'd0);

        // Fill FIFO exactly with TX stalled, then hold the next answer's word
        tx_ready = 1'b0;
        answer_size_in_bytes = 32'd1024;
        stalls = 0;
        push_word(32'd1024);
        for (int i = 0; i < 256; i++) begin
            send_word({8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)}, 1'(i == 255), waits);
            stalls += waits - 1;
            push_word({8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)});
        end
        chk("t3_fill_stalls", 32'(stalls), 32'd0);
        chk("t3_ready_after_full", 32'(input_ready), 32'd0);
        @(posedge i_clk);
        #1;
        chk("t3_hdr_valid", 32'(tx_valid), 32'd1);
        chk("t3_hdr_byte0", 32'(tx_data), 32'h00);
        chk("t3_hdr_ready", 32'(input_ready), 32'd0);
        answer_size_in_bytes = 32'd4;
        fd_before = fd_cnt;
        tx_ready  = 1'b1;
        send_word(32'h87654321, 1'b1, waits);
        chk("t3_held_until_done", 32'(fd_cnt), 32'(fd_before + 1));
        wait_frame(fd_before + 2, 1'b0);
        push_word(32'h00000004);
        push_word(32'h87654321);
        check_frame("t3");
        chk("t3_mismatch", 32'(length_mismatch), 32'd0);

        // Reported length disagrees with buffered words
        answer_size_in_bytes = 32'd8;
        fd_before = fd_cnt;
        send_word(32'h13121110, 1'b0, waits);
        send_word(32'h17161514, 1'b0, waits);
        send_word(32'h1B1A1918, 1'b1, waits);
        wait_frame(fd_before + 1, 1'b0);
        chk("t4_mismatch", 32'(length_mismatch), 32'd1);
        push_word(32'h00000008);
        push_word(32'h13121110);
        push_word(32'h17161514);
        push_word(32'h1B1A1918);
        check_frame("t4");

        // Back-to-back answers
        fd_before = fd_cnt;
        send_word(32'hA3A2A1A0, 1'b0, waits);
        send_word(32'hA7A6A5A4, 1'b1, waits);
        send_word(32'hB3B2B1B0, 1'b0, waits);
        chk("t6_second_held", 32'(fd_cnt), 32'(fd_before + 1));
        send_word(32'hB7B6B5B4, 1'b1, waits);
        wait_frame(fd_before + 2, 1'b0);
        push_word(32'h00000008);
        push_word(32'hA3A2A1A0);
        push_word(32'hA7A6A5A4);
        push_word(32'h00000008);
        push_word(32'hB3B2B1B0);
        push_word(32'hB7B6B5B4);
        check_frame("t6");
        chk("t6_mismatch_sticky", 32'(length_mismatch), 32'd1);

        // Reset in the middle of the payload
        answer_size_in_bytes = 32'd4;
        send_word(32'h44332211, 1'b1, waits);
        waits = 0;
        while (rx_q.size() < 5 && waits < 100) begin
            @(posedge i_clk);
            #1;
            waits++;
        end
        chk("t5_bytes_before_rst", 32'(rx_q.size()), 32'd5);
        i_rst = 1'b1;
        #1;
        chk("t5_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_input_ready", 32'(input_ready), 32'd1);
        chk("t5_rst_mismatch", 32'(length_mismatch), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        rx_q.delete();
        fd_before = fd_cnt;
        send_word(32'h44332211, 1'b1, waits);
        wait_frame(fd_before + 1, 1'b0);
        push_word(32'h00000004);
        push_word(32'h44332211);
        check_frame("t5");
        chk("t5_mismatch", 32'(length_mismatch), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
